instr_fetch_unit: RTL and testbench

Instruction fetch unit for the FRiscV CPU. Issues word fetches to instruction memory, buffers returned instructions in a small FIFO, and presents the head instruction to the main controller. It supplies op_code/func3/func7 already split out, plus the instruction's PC. Accepts redirects (branch/jump targets) from the datapath: it flushes buffered and in-flight fetches, then resumes at the new PC.

---
 rtl/instr_fetch_unit.sv | 173 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: FRiscV instruction fetch. Issues single-outstanding word
// fetches, buffers responses in a small FIFO and presents the head instruction
// with its PC and decoded op_code/func3/func7. Redirects flush buffered and
// in-flight fetches and restart at the new PC.
// Optional feature macro: IFU_MISALIGN_CHK_EN (misaligned-redirect detection).
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                BUF_DEPTH = 2,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    output logic              imem_req_out,
    output logic [ADDR_W-1:0] imem_addr_out,
    input  logic              imem_gnt_in,
    input  logic              imem_rvalid_in,
    input  logic [31:0]       imem_rdata_in,
    output logic              instr_valid_out,
    input  logic              instr_ready_in,
    output logic [31:0]       instr_out,
    output logic [ADDR_W-1:0] instr_pc_out,
    output logic [6:0]        op_code_out,
    output logic [2:0]        func3_out,
    output logic [6:0]        func7_out,
    input  logic              redirect_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    output logic              misalign_out
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, FLUSH} state_t;

    state_t            state, state_nxt, resume;
    logic [ADDR_W-1:0] addr_q, addr_nxt;          // address of current/next request
    logic [ADDR_W-1:0] flight_pc;                 // PC of the granted, in-flight fetch
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_nxt;  // redirect parked while REQ waits for gnt
    logic              pend_q, pend_nxt;
    logic [ADDR_W-1:0] redir_pc;
    logic              redir_mis, misalign_q, mis_nxt;
    logic              push, pop;

    logic [31:0]       buf_instr [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc    [BUF_DEPTH];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_after;

    assign redir_pc = {redirect_pc_in[ADDR_W-1:2], 2'b00};

`ifdef IFU_MISALIGN_CHK_EN
    assign redir_mis = redirect_in && (redirect_pc_in[1:0] != 2'b00);
`else
    // Low address bits are silently dropped; misalignment is never flagged.
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc_in[1:0];
    assign redir_mis = 1'b0;
`endif

    assign pop             = (count != '0) && instr_ready_in;
    assign count_after     = pop ? count : count + CW'(1);  // occupancy after a push
    assign instr_valid_out = (count != '0);
    assign instr_out       = instr_valid_out ? buf_instr[rd_ptr] : '0;
    assign instr_pc_out    = instr_valid_out ? buf_pc[rd_ptr] : '0;
    assign op_code_out     = instr_out[6:0];
    assign func3_out       = instr_out[14:12];
    assign func7_out       = instr_out[31:25];
    assign imem_req_out    = (state == REQ);
    assign imem_addr_out   = addr_q;
    assign misalign_out    = misalign_q;

    // Next-state, next fetch address and push decision; redirect has priority.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        pend_nxt     = pend_q;
        redir_pc_nxt = redir_pc_q;
        push         = 1'b0;
        mis_nxt      = redirect_in ? redir_mis : misalign_q;
        resume       = mis_nxt ? IDLE : REQ;
        case (state)
            IDLE: begin
                if (redirect_in) begin
                    addr_nxt  = redir_pc;
                    state_nxt = resume;
                end else if (!misalign_q && count < DEPTH_C) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (imem_gnt_in) begin
                    if (redirect_in) begin
                        addr_nxt  = redir_pc;
                        state_nxt = FLUSH;
                    end else if (pend_q) begin
                        addr_nxt  = redir_pc_q;
                        state_nxt = FLUSH;
                    end else begin
                        addr_nxt  = addr_q + ADDR_W'(4);
                        state_nxt = WAIT;
                    end
                    pend_nxt = 1'b0;
                end else if (redirect_in) begin
                    // Address must stay put until gnt; remember where to go.
                    pend_nxt     = 1'b1;
                    redir_pc_nxt = redir_pc;
                end
            end
            WAIT: begin
                if (redirect_in) begin
                    addr_nxt  = redir_pc;
                    state_nxt = imem_rvalid_in ? resume : FLUSH;
                end else if (imem_rvalid_in) begin
                    push      = 1'b1;
                    state_nxt = (count_after < DEPTH_C) ? REQ : IDLE;
                end
            end
            FLUSH: begin
                if (redirect_in) addr_nxt = redir_pc;
                if (imem_rvalid_in) state_nxt = resume;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            addr_q     <= RESET_PC;
            flight_pc  <= '0;
            pend_q     <= 1'b0;
            redir_pc_q <= '0;
            misalign_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr_q     <= addr_nxt;
            pend_q     <= pend_nxt;
            redir_pc_q <= redir_pc_nxt;
            misalign_q <= mis_nxt;
            if (state == REQ && imem_gnt_in) flight_pc <= addr_q;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the buffer.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only observed through count-gated outputs.
    always_ff @(posedge clk_in) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata_in;
            buf_pc[wr_ptr]    <= flight_pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with a latency-programmable memory
// responder and a pop monitor. Inputs change on the falling edge.
module tb_instr_fetch_unit;
    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic        instr_valid_out;
    logic        instr_ready_in;
    logic [31:0] instr_out;
    logic [31:0] instr_pc_out;
    logic [6:0]  op_code_out;
    logic [2:0]  func3_out;
    logic [6:0]  func7_out;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        misalign_out;

    instr_fetch_unit dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .imem_req_out(imem_req_out), .imem_addr_out(imem_addr_out),
        .imem_gnt_in(imem_gnt_in), .imem_rvalid_in(imem_rvalid_in),
        .imem_rdata_in(imem_rdata_in), .instr_valid_out(instr_valid_out),
        .instr_ready_in(instr_ready_in), .instr_out(instr_out),
        .instr_pc_out(instr_pc_out), .op_code_out(op_code_out),
        .func3_out(func3_out), .func7_out(func7_out),
        .redirect_in(redirect_in), .redirect_pc_in(redirect_pc_in),
        .misalign_out(misalign_out)
    );

    always #5 clk_in = ~clk_in;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h8) return 32'h00A0_0093;
        return 32'hB400_5000 | (a & 32'h0000_0FFF);
    endfunction

    // Memory responder: rvalid arrives lat cycles after the granting edge.
    int          lat = 1;
    int          dly = 0;
    logic [31:0] pend_addr = '0;
    initial begin
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = '0;
        forever begin
            @(negedge clk_in); #1;
            imem_rvalid_in = 1'b0;
            if (!rst_n_in) dly = 0;
            else begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) begin
                        imem_rvalid_in = 1'b1;
                        imem_rdata_in  = mem_word(pend_addr);
                    end
                end
                if (imem_req_out && imem_gnt_in) begin
                    dly       = lat;
                    pend_addr = imem_addr_out;
                end
            end
        end
    end

    // Pop monitor: records every head consumed by the next rising edge.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
    } pop_t;
    pop_t popped[$];
    initial forever begin
        @(negedge clk_in); #2;
        if (rst_n_in && instr_valid_out && instr_ready_in)
            popped.push_back('{instr_pc_out, instr_out, op_code_out, func3_out, func7_out});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    // Bounded wait for a request; flags any valid head seen on the way.
    task automatic wait_req(input string tag, output logic stale);
        int n = 0;
        stale = 1'b0;
        while (!imem_req_out && n < 50) begin
            step(1);
            if (instr_valid_out) stale = 1'b1;
            n++;
        end
        chk({tag, "_req"}, 32'(imem_req_out), 32'd1);
    endtask

    task automatic chk_seq(input string tag, input logic [31:0] base, input int min_n);
        chk({tag, "_npop"}, 32'(popped.size() >= min_n), 32'd1);
        foreach (popped[i]) begin
            chk({tag, "_pc"},  popped[i].pc,  base + 32'(4 * i));
            chk({tag, "_ins"}, popped[i].ins, mem_word(base + 32'(4 * i)));
        end
    endtask

    task automatic redirect(input logic [31:0] pc);
        redirect_in    = 1'b1;
        redirect_pc_in = pc;
        step(1);
        redirect_in    = 1'b0;
    endtask

    logic stale;

    initial begin
        rst_n_in = 1'b0; imem_gnt_in = 1'b1; instr_ready_in = 1'b0;
        redirect_in = 1'b0; redirect_pc_in = '0;
        step(2);
        chk("rst_req",   32'(imem_req_out),    32'd0);
        chk("rst_addr",  imem_addr_out,        32'h0);
        chk("rst_valid", 32'(instr_valid_out), 32'd0);
        chk("rst_instr", instr_out,            32'h0);
        chk("rst_pc",    instr_pc_out,         32'h0);
        chk("rst_op",    32'(op_code_out),     32'h0);
        chk("rst_mis",   32'(misalign_out),    32'd0);

        // Startup: first request one cycle after release, then fill to two.
        rst_n_in = 1'b1;
        step(1);
        chk("t1_req0",  32'(imem_req_out), 32'd1);
        chk("t1_addr0", imem_addr_out,     32'h0);
        step(1);
        chk("t1_wait",  32'(imem_req_out), 32'd0);
        step(1);
        chk("t1_valid", 32'(instr_valid_out), 32'd1);
        chk("t1_hpc",   instr_pc_out,         32'h0);
        chk("t1_hins",  instr_out,            32'hB400_5000);
        chk("t1_req1",  32'(imem_req_out),    32'd1);
        chk("t1_addr1", imem_addr_out,        32'h4);
        step(2);
        chk("t2_full_req", 32'(imem_req_out), 32'd0);
        chk("t2_full_hpc", instr_pc_out,      32'h0);
        step(1);
        chk("t2_full_req2", 32'(imem_req_out), 32'd0);

        // Drain and stream, then back-pressure again.
        instr_ready_in = 1'b1;
        step(12);
        instr_ready_in = 1'b0;
        step(8);
        chk("t2_bp_req",   32'(imem_req_out),    32'd0);
        chk("t2_bp_valid", 32'(instr_valid_out), 32'd1);
        chk_seq("t2", 32'h0, 4);
        if (popped.size() >= 3) begin
            chk("t3_op4",  32'(popped[1].op), 32'h04);
            chk("t3_f3_4", 32'(popped[1].f3), 32'h5);
            chk("t3_f7_4", 32'(popped[1].f7), 32'h5A);
            chk("t3_op8",  32'(popped[2].op), 32'h13);
            chk("t3_f3_8", 32'(popped[2].f3), 32'h0);
            chk("t3_f7_8", 32'(popped[2].f7), 32'h0);
        end

        // Redirect while a fetch is in flight (slow response is discarded).
        lat = 3;
        instr_ready_in = 1'b1;
        wait_req("t4_pre", stale);
        step(1);
        chk("t4_inwait", 32'(imem_req_out), 32'd0);
        redirect(32'h100);
        popped.delete();
        chk("t4_flush_valid", 32'(instr_valid_out), 32'd0);
        chk("t4_flush_req",   32'(imem_req_out),    32'd0);
        wait_req("t4", stale);
        chk("t4_addr",  imem_addr_out, 32'h100);
        chk("t4_stale", 32'(stale),    32'd0);
        lat = 1;
        step(10);
        instr_ready_in = 1'b0;
        step(8);
        chk_seq("t4", 32'h100, 3);

        // Grant withheld: address holds, then PC wraps to zero.
        imem_gnt_in = 1'b0;
        redirect(32'hFFFF_FFFC);
        chk("t5_req",   32'(imem_req_out),    32'd1);
        chk("t5_valid", 32'(instr_valid_out), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("t5_hold", imem_addr_out, 32'hFFFF_FFFC);
            step(1);
        end
        chk("t5_hold_req", 32'(imem_req_out), 32'd1);
        imem_gnt_in = 1'b1;
        step(1);
        wait_req("t5_wrap", stale);
        chk("t5_wrap_addr", imem_addr_out, 32'h0);
        chk("t5_head_pc",   instr_pc_out,  32'hFFFF_FFFC);
        chk("t5_head_ins",  instr_out,     32'hB400_5FFC);

        // Redirect while the request is still waiting for its grant.
        imem_gnt_in = 1'b0;
        redirect(32'h300);
        chk("t5b_req",   32'(imem_req_out),    32'd1);
        chk("t5b_addr",  imem_addr_out,        32'h0);
        chk("t5b_valid", 32'(instr_valid_out), 32'd0);
        step(2);
        chk("t5b_addr2", imem_addr_out, 32'h0);
        imem_gnt_in = 1'b1;
        step(1);
        wait_req("t5b", stale);
        chk("t5b_new_addr", imem_addr_out, 32'h300);
        chk("t5b_stale",    32'(stale),    32'd0);
        popped.delete();
        instr_ready_in = 1'b1;
        step(10);
        instr_ready_in = 1'b0;
        step(8);
        chk_seq("t5b", 32'h300, 3);

        // Misaligned redirect.
        redirect(32'h102);
        chk("t6_valid", 32'(instr_valid_out), 32'd0);
`ifdef IFU_MISALIGN_CHK_EN
        chk("t6_mis", 32'(misalign_out), 32'd1);
        stale = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (imem_req_out) stale = 1'b1;
            step(1);
        end
        chk("t6_blocked", 32'(stale), 32'd0);
        chk("t6_mis_sticky", 32'(misalign_out), 32'd1);
        redirect(32'h200);
        chk("t6_mis_clr", 32'(misalign_out), 32'd0);
        chk("t6_req",     32'(imem_req_out), 32'd1);
        chk("t6_addr",    imem_addr_out,     32'h200);
`else
        chk("t6_mis",  32'(misalign_out), 32'd0);
        chk("t6_req",  32'(imem_req_out), 32'd1);
        chk("t6_addr", imem_addr_out,     32'h100);
`endif

        // Reset in the middle of a transaction.
        lat = 3;
        step(1);
        rst_n_in = 1'b0;
        #1;
        chk("t7_req",  32'(imem_req_out),    32'd0);
        chk("t7_addr", imem_addr_out,        32'h0);
        chk("t7_mis",  32'(misalign_out),    32'd0);
        step(3);
        rst_n_in = 1'b1;
        step(1);
        chk("t7_restart_req",  32'(imem_req_out),    32'd1);
        chk("t7_restart_addr", imem_addr_out,        32'h0);
        chk("t7_restart_vld",  32'(instr_valid_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
